dmem_responder: RTL and testbench

Data-memory responder on the core's LSU bus. It serves the LSU read port (request/acknowledge with programmable wait states) and the LSU write port (posted, byte-enabled, single-cycle commit) from an internal word-organised RAM. It sits between the core's load/store unit and on-chip data storage, and flags misaligned or out-of-range accesses.

---
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the LSU bus: wait-stated read port with
// acknowledge, posted byte-enabled write port, and fault flagging for
// misaligned or out-of-range accesses.
module dmem_responder #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clk_en,
    input  logic          i_lsu_read,
    input  logic [AW-1:0] i_r_lsu_addr,
    output logic [DW-1:0] o_r_lsu_data,
    output logic          o_lsu_ack,
    input  logic          i_lsu_write,
    input  logic [AW-1:0] i_w_lsu_addr,
    input  logic [3:0]    i_w_lsu_byte_en,
    input  logic [DW-1:0] i_w_lsu_data,
    output logic          o_fault
);

    localparam int unsigned IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t        state, state_next;
    logic [2:0]    cnt, cnt_next;
    logic          capture;

    logic [IW-1:0] rd_idx;
    logic          rd_legal;

    logic [DW-1:0] mem [DEPTH];

    logic [IW-1:0] w_idx, r_idx_now, cap_idx;
    logic          w_legal, w_commit, r_legal_now, cap_legal;
    logic [DW-1:0] cap_word;

    // Word-aligned and inside the array.
    function automatic logic addr_legal(input logic [AW-1:0] a);
        return (a[1:0] == 2'b00) && ((a >> (IW + 2)) == '0);
    endfunction

    // Address decode and write-commit qualification.
    always_comb begin
        w_idx       = i_w_lsu_addr[IW+1:2];
        w_legal     = addr_legal(i_w_lsu_addr);
        w_commit    = i_rst && i_clk_en && i_lsu_write && w_legal;
        r_idx_now   = i_r_lsu_addr[IW+1:2];
        r_legal_now = addr_legal(i_r_lsu_addr);
    end

    // Read FSM next-state logic; capture marks the edge that enters ACK.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (i_lsu_read) begin
                    if (WAIT_STATES > 0) begin
                        state_next = S_WAIT;
                        cnt_next   = 3'(WAIT_STATES - 1);
                    end else begin
                        state_next = S_ACK;
                        capture    = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_next = S_ACK;
                    capture    = 1'b1;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            S_ACK: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Capture word with same-edge write forwarding per byte lane.
    // With zero wait states the capture happens straight from IDLE, so the
    // live request address is used instead of the latched one.
    always_comb begin
        cap_idx   = (state == S_IDLE) ? r_idx_now : rd_idx;
        cap_legal = (state == S_IDLE) ? r_legal_now : rd_legal;
        cap_word  = mem[cap_idx];
        for (int unsigned n = 0; n < 4; n++) begin
            if (w_commit && (w_idx == cap_idx) && i_w_lsu_byte_en[n]) begin
                cap_word[8*n +: 8] = i_w_lsu_data[8*n +: 8];
            end
        end
    end

    // FSM state, request latch and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            rd_idx       <= '0;
            rd_legal     <= 1'b0;
            o_lsu_ack    <= 1'b0;
            o_r_lsu_data <= '0;
            o_fault      <= 1'b0;
        end else if (i_clk_en) begin
            state <= state_next;
            cnt   <= cnt_next;
            if ((state == S_IDLE) && i_lsu_read) begin
                rd_idx   <= r_idx_now;
                rd_legal <= r_legal_now;
            end
            o_lsu_ack <= capture;
            if (capture) begin
                o_r_lsu_data <= cap_legal ? cap_word : '0;
            end
            o_fault <= (capture && !cap_legal) || (i_lsu_write && !w_legal);
        end
    end

    // Byte-lane RAM writes; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_commit) begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (i_w_lsu_byte_en[n]) begin
                    mem[w_idx][8*n +: 8] <= i_w_lsu_data[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (0 and 3 wait states) share the write
// port; a transaction-level model predicts ack timing, data and faults.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned NW    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clk_en;
    logic [1:0]  rd;
    logic [31:0] raddr [2];
    logic        wr;
    logic [31:0] waddr;
    logic [3:0]  wbe;
    logic [31:0] wdata;

    logic [31:0] rdata0, rdata1;
    logic        ack0, ack1, fault0, fault1;

    dmem_responder #(.AW(32), .DW(32), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .i_clk(clk), .i_rst(rst_n), .i_clk_en(clk_en),
        .i_lsu_read(rd[0]), .i_r_lsu_addr(raddr[0]),
        .o_r_lsu_data(rdata0), .o_lsu_ack(ack0),
        .i_lsu_write(wr), .i_w_lsu_addr(waddr), .i_w_lsu_byte_en(wbe),
        .i_w_lsu_data(wdata), .o_fault(fault0)
    );

    dmem_responder #(.AW(32), .DW(32), .DEPTH(DEPTH), .WAIT_STATES(3)) dut1 (
        .i_clk(clk), .i_rst(rst_n), .i_clk_en(clk_en),
        .i_lsu_read(rd[1]), .i_r_lsu_addr(raddr[1]),
        .o_r_lsu_data(rdata1), .o_lsu_ack(ack1),
        .i_lsu_write(wr), .i_w_lsu_addr(waddr), .i_w_lsu_byte_en(wbe),
        .i_w_lsu_data(wdata), .o_fault(fault1)
    );

    // Reference model state
    logic [31:0] mmem [DEPTH];
    bit          m_pend  [2];
    bit          m_acked [2];
    int          m_left  [2];
    logic [31:0] m_addr  [2];
    bit          e_ack   [2];
    bit          e_fault [2];
    logic [31:0] e_data  [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < DEPTH * 4);
    endfunction

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic get_ack(input int d);
        return (d == 0) ? ack0 : ack1;
    endfunction

    function automatic logic get_fault(input int d);
        return (d == 0) ? fault0 : fault1;
    endfunction

    function automatic logic [31:0] get_data(input int d);
        return (d == 0) ? rdata0 : rdata1;
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned sel;
        logic [31:0] a;
        sel = $urandom_range(0, 9);
        a = 32'($urandom_range(0, NW - 1)) * 4;
        if (sel == 0) a = a + 32'($urandom_range(1, 3));
        else if (sel == 1) a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
        return a;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = 0; m_acked[d] = 0; m_left[d] = 0;
            e_ack[d] = 0; e_fault[d] = 0; e_data[d] = '0;
        end
    endtask

    // One clock: advance the model on the edge, then compare outputs.
    task automatic tick();
        bit wf;
        logic [31:0] mask;
        @(posedge clk);
        if (rst_n && clk_en) begin
            wf = 0;
            if (wr) begin
                if (legal(waddr)) begin
                    mask = '0;
                    for (int n = 0; n < 4; n++)
                        if (wbe[n]) mask = mask | (32'hFF << (8 * n));
                    mmem[waddr / 4] = (mmem[waddr / 4] & ~mask) | (wdata & mask);
                end else begin
                    wf = 1;
                end
            end
            for (int d = 0; d < 2; d++) begin
                e_ack[d] = 0;
                e_fault[d] = wf;
                if (m_acked[d]) begin
                    m_acked[d] = 0;
                end else if (!m_pend[d] && rd[d]) begin
                    m_pend[d] = 1;
                    m_left[d] = ws_of(d);
                    m_addr[d] = raddr[d];
                end else if (m_pend[d]) begin
                    m_left[d]--;
                end
                if (m_pend[d] && m_left[d] == 0) begin
                    m_pend[d] = 0;
                    m_acked[d] = 1;
                    e_ack[d] = 1;
                    e_data[d] = legal(m_addr[d]) ? mmem[m_addr[d] / 4] : 32'h0;
                    if (!legal(m_addr[d])) e_fault[d] = 1;
                end
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("ack%0d", d), 32'(get_ack(d)), 32'(e_ack[d]));
            check($sformatf("fault%0d", d), 32'(get_fault(d)), 32'(e_fault[d]));
            if (e_ack[d]) check($sformatf("data%0d", d), get_data(d), e_data[d]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        check("rst_ack0", 32'(ack0), 32'h0);
        check("rst_ack1", 32'(ack1), 32'h0);
        check("rst_fault0", 32'(fault0), 32'h0);
        check("rst_fault1", 32'(fault1), 32'h0);
        check("rst_data0", rdata0, 32'h0);
        check("rst_data1", rdata1, 32'h0);
    endtask

    task automatic write_word(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        wr = 1'b1; waddr = a; wbe = be; wdata = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic wait_ack(input int d, output logic [31:0] got, output int cyc);
        cyc = 0;
        got = '0;
        for (int i = 0; i < 30; i++) begin
            tick();
            cyc++;
            if (e_ack[d]) begin
                got = get_data(d);
                return;
            end
        end
        check("ack_timeout", 32'h0, 32'h1);
    endtask

    task automatic read_word(input int d, input logic [31:0] a, output logic [31:0] got, output int cyc);
        rd[d] = 1'b1; raddr[d] = a;
        wait_ack(d, got, cyc);
        rd[d] = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        int cyc;
        rst_n = 1'b0; clk_en = 1'b1; rd = '0; raddr[0] = '0; raddr[1] = '0;
        wr = 1'b0; waddr = '0; wbe = '0; wdata = '0;
        model_clear();
        #2;
        do_reset();
        tick(); tick();
        rst_n = 1'b1;

        for (int i = 0; i < NW; i++) write_word(32'(i * 4), 4'hF, $urandom);

        // Full-word write then zero-wait read
        write_word(32'h10, 4'hF, 32'hDEADBEEF);
        read_word(0, 32'h10, got, cyc);
        check("t1_data", got, 32'hDEADBEEF);
        check("t1_lat", 32'(cyc), 32'd1);

        // Byte-lane merge
        write_word(32'h20, 4'hF, 32'h11223344);
        write_word(32'h20, 4'b0101, 32'hAABBCCDD);
        read_word(0, 32'h20, got, cyc);
        check("t2_data", got, 32'h11BB33DD);

        // Forwarding on the capture edge with three wait states
        write_word(32'h30, 4'hF, 32'hFFFFFFFF);
        rd[1] = 1'b1; raddr[1] = 32'h30;
        tick(); tick(); tick();
        wr = 1'b1; waddr = 32'h30; wbe = 4'b0011; wdata = 32'h5555AAAA;
        tick();
        wr = 1'b0; rd[1] = 1'b0;
        check("t3_ack", 32'(ack1), 32'h1);
        check("t3_data", rdata1, 32'hFFFFAAAA);
        tick();

        // Misaligned write, out-of-range read
        write_word(32'h22, 4'hF, 32'h0BADF00D);
        check("t4_wfault", 32'(fault0), 32'h1);
        tick();
        check("t4_wfault_end", 32'(fault0), 32'h0);
        rd[0] = 1'b1; raddr[0] = DEPTH * 4;
        wait_ack(0, got, cyc);
        rd[0] = 1'b0;
        check("t4_rdata", got, 32'h0);
        check("t4_rfault", 32'(fault0), 32'h1);
        tick();
        read_word(0, 32'h20, got, cyc);
        check("t4_unchanged", got, 32'h11BB33DD);

        // Clock-enable freeze mid-wait with a suppressed write
        rd[1] = 1'b1; raddr[1] = 32'h30;
        tick(); tick();
        clk_en = 1'b0;
        wr = 1'b1; waddr = 32'h30; wbe = 4'hF; wdata = 32'h0;
        repeat (5) tick();
        wr = 1'b0; clk_en = 1'b1;
        wait_ack(1, got, cyc);
        rd[1] = 1'b0;
        check("t5_lat", 32'(cyc + 7), 32'd9);
        check("t5_data", got, 32'hFFFFAAAA);
        tick();

        // Reset during WAIT drops the read; memory survives
        rd[1] = 1'b1; raddr[1] = 32'h10;
        tick(); tick();
        do_reset();
        wr = 1'b1; waddr = 32'h10; wbe = 4'hF; wdata = 32'h0;
        tick();
        wr = 1'b0; rd[1] = 1'b0;
        rst_n = 1'b1;
        read_word(1, 32'h10, got, cyc);
        check("t6_data", got, 32'hDEADBEEF);
        check("t6_lat", 32'(cyc), 32'd4);

        // Randomized mixed traffic
        for (int c = 0; c < 1500; c++) begin
            clk_en = ($urandom_range(0, 9) != 0);
            wr = 1'($urandom_range(0, 1));
            waddr = rand_addr();
            wbe = 4'($urandom);
            wdata = $urandom;
            for (int d = 0; d < 2; d++) begin
                if (!(m_pend[d] || (rd[d] && !m_acked[d]))) begin
                    rd[d] = ($urandom_range(0, 2) == 0);
                    raddr[d] = rand_addr();
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
